// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port 16 KiB x 8 video RAM between the 6502 bus interface
// (CPU port) and the scan-out pixel fetcher (video port), one access per clock.
// Video wins by default; a starvation counter forces a CPU slot once a pending
// CPU access has lost MAX_WAIT consecutive cycles.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   cpu_req/we/addr/wdata   CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_rdata      one-cycle completion pulse, read data
//   vid_req, vid_addr       video read request, evaluated every cycle
//   vid_grant               combinational accept of this cycle's vid_req
//   vid_valid, vid_data     video read return, 3 cycles after grant
//   vram_we/addr/din        registered drive to the RAM
//   vram_dout               RAM synchronous read data
module vram_arbiter #(
    parameter int MAX_WAIT = 7,
    parameter int ADDR_W   = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_grant,
    output logic              vid_valid,
    output logic [7:0]        vid_data,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_din,
    input  logic [7:0]        vram_dout
);

    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_PEND = 3'd1;
    localparam logic [2:0] C_RD1  = 3'd2;
    localparam logic [2:0] C_RD2  = 3'd3;
    localparam logic [2:0] C_ACK  = 3'd4;

    logic [2:0]        cstate_r;
    logic              lat_we_r;
    logic [ADDR_W-1:0] lat_addr_r;
    logic [7:0]        lat_wdata_r;
    logic [3:0]        wait_cnt_r;

    logic              cpu_ack_r;
    logic [7:0]        cpu_rdata_r;
    logic              vid_valid_r;
    logic [7:0]        vid_data_r;
    logic              vram_we_r;
    logic [ADDR_W-1:0] vram_addr_r;
    logic [7:0]        vram_din_r;

    // Read pipeline tags: [0] = RAM address stage, [1] = RAM data stage.
    // rd_cpu_r marks reads owned by the CPU so returned data is routed correctly.
    logic [1:0]        rd_vld_r;
    logic [1:0]        rd_cpu_r;

    logic              pend_s;
    logic              forced_s;
    logic              cpu_grant_s;
    logic              vid_grant_s;

    assign pend_s   = (cstate_r == C_PEND);
    assign forced_s = pend_s && (wait_cnt_r == 4'(MAX_WAIT));

    // Per-cycle grant priority: forced CPU, then video, then normal CPU.
    always_comb begin
        cpu_grant_s = 1'b0;
        vid_grant_s = 1'b0;
        if (forced_s) begin
            cpu_grant_s = 1'b1;
        end else if (vid_req) begin
            vid_grant_s = 1'b1;
        end else if (pend_s) begin
            cpu_grant_s = 1'b1;
        end else begin
            cpu_grant_s = 1'b0;
            vid_grant_s = 1'b0;
        end
    end

    // CPU request FSM; the latched request completes even if cpu_req drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            cstate_r    <= C_IDLE;
            lat_we_r    <= 1'b0;
            lat_addr_r  <= '0;
            lat_wdata_r <= 8'h00;
        end else begin
            case (cstate_r)
                C_IDLE: begin
                    if (cpu_req && !cpu_ack_r) begin
                        lat_we_r    <= cpu_we;
                        lat_addr_r  <= cpu_addr;
                        lat_wdata_r <= cpu_wdata;
                        cstate_r    <= C_PEND;
                    end
                end
                C_PEND: begin
                    if (cpu_grant_s) begin
                        cstate_r <= lat_we_r ? C_ACK : C_RD1;
                    end
                end
                C_RD1:   cstate_r <= C_RD2;
                C_RD2:   cstate_r <= C_ACK;
                C_ACK:   cstate_r <= C_IDLE;
                default: cstate_r <= C_IDLE;
            endcase
        end
    end

    // Starvation counter: counts cycles a pending CPU access loses to video.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if (!pend_s || cpu_grant_s) begin
            wait_cnt_r <= 4'd0;
        end else if (vid_grant_s && (wait_cnt_r != 4'(MAX_WAIT))) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end
    end

    // RAM drive registers loaded at the granting edge; idle cycles hold address.
    always_ff @(posedge clock) begin
        if (reset) begin
            vram_we_r   <= 1'b0;
            vram_addr_r <= '0;
            vram_din_r  <= 8'h00;
        end else if (cpu_grant_s) begin
            vram_we_r   <= lat_we_r;
            vram_addr_r <= lat_addr_r;
            if (lat_we_r) begin
                vram_din_r <= lat_wdata_r;
            end
        end else if (vid_grant_s) begin
            vram_we_r   <= 1'b0;
            vram_addr_r <= vid_addr;
        end else begin
            vram_we_r   <= 1'b0;
        end
    end

    // Owner-tag pipeline that follows each read through the RAM latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_vld_r <= 2'b00;
            rd_cpu_r <= 2'b00;
        end else begin
            rd_vld_r <= {rd_vld_r[0], vid_grant_s | (cpu_grant_s & ~lat_we_r)};
            rd_cpu_r <= {rd_cpu_r[0], cpu_grant_s};
        end
    end

    // Return path: capture RAM data for the tagged owner, plus CPU write acks.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_ack_r   <= 1'b0;
            cpu_rdata_r <= 8'h00;
            vid_valid_r <= 1'b0;
            vid_data_r  <= 8'h00;
        end else begin
            cpu_ack_r   <= (cpu_grant_s & lat_we_r) | (rd_vld_r[1] & rd_cpu_r[1]);
            vid_valid_r <= rd_vld_r[1] & ~rd_cpu_r[1];
            if (rd_vld_r[1] && rd_cpu_r[1]) begin
                cpu_rdata_r <= vram_dout;
            end
            if (rd_vld_r[1] && !rd_cpu_r[1]) begin
                vid_data_r <= vram_dout;
            end
        end
    end

    assign cpu_ack   = cpu_ack_r;
    assign cpu_rdata = cpu_rdata_r;
    assign vid_grant = vid_grant_s;
    assign vid_valid = vid_valid_r;
    assign vid_data  = vid_data_r;
    assign vram_we   = vram_we_r;
    assign vram_addr = vram_addr_r;
    assign vram_din  = vram_din_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Randomized bench for vram_arbiter with a behavioural RAM and a transaction
// level reference model that schedules expected outputs by cycle number.
module tb_vram_arbiter;

    localparam int MAX_WAIT = 7;
    localparam int ADDR_W   = 14;
    localparam int NCYC     = 4000;

    logic              clock = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_grant, vid_valid;
    logic [7:0]        vid_data;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_din;
    logic [7:0]        vram_dout;

    vram_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_grant(vid_grant),
        .vid_valid(vid_valid), .vid_data(vid_data),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
        .vram_dout(vram_dout)
    );

    always #5 clock = ~clock;

    // Behavioural single-port synchronous RAM.
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clock) begin
        if (vram_we) ram[vram_addr] <= vram_din;
        vram_dout <= ram[vram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int c;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, c, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0]        shadow [0:(1<<ADDR_W)-1];
    logic              exp_vv  [0:NCYC+7];
    logic [7:0]        exp_vd  [0:NCYC+7];
    logic              exp_ack [0:NCYC+7];
    logic              exp_rdc [0:NCYC+7];
    logic [7:0]        exp_rd  [0:NCYC+7];
    logic              exp_we  [0:NCYC+7];
    logic [ADDR_W-1:0] exp_addr[0:NCYC+7];
    logic [7:0]        exp_din [0:NCYC+7];

    logic              m_pend, m_we, m_vg, m_cg, m_forced, m_accept;
    logic [ADDR_W-1:0] m_addr, last_addr;
    logic [7:0]        m_wdata, last_din;
    int                m_waits, m_ack_cycle;
    logic              hold, dropped;
    int                hold_start;
    int                phase;

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) begin
            ram[i]    = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        for (int i = 0; i < NCYC+8; i++) begin
            exp_vv[i] = 1'b0; exp_vd[i] = 8'h00; exp_ack[i] = 1'b0; exp_rdc[i] = 1'b0;
            exp_rd[i] = 8'h00; exp_we[i] = 1'b0; exp_addr[i] = '0; exp_din[i] = 8'h00;
        end
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
        vid_req = 1'b0; vid_addr = '0;
        m_pend = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = 8'h00; m_waits = 0;
        m_ack_cycle = -5; last_addr = '0; last_din = 8'h00;
        hold = 1'b0; dropped = 1'b0; hold_start = 0;

        for (c = 0; c < NCYC; c++) begin
            @(posedge clock);
            #1;
            // ---- stimulus ----
            reset = (c < 2) || ($urandom % 300 == 0);
            phase = (c / 150) % 3;
            if (phase == 0)      vid_req = ($urandom % 2) == 0;
            else if (phase == 1) vid_req = ($urandom % 20) != 0;
            else                 vid_req = ($urandom % 10) == 0;
            vid_addr = ADDR_W'($urandom_range(0, 31));

            if (hold && c == m_ack_cycle + 1) begin
                hold = 1'b0;
            end else if (hold && c > hold_start && ($urandom % 12) == 0) begin
                dropped = 1'b1;
            end else if (!hold && c > m_ack_cycle + 1 && ($urandom % 3) == 0) begin
                hold = 1'b1; dropped = 1'b0; hold_start = c;
                cpu_we    = ($urandom % 2) == 0;
                cpu_addr  = ADDR_W'($urandom_range(0, 31));
                cpu_wdata = 8'($urandom);
            end
            cpu_req = hold && !dropped;

            // ---- reference model: arbitration rules for this cycle ----
            m_forced = m_pend && (m_waits == MAX_WAIT);
            m_vg = 1'b0; m_cg = 1'b0;
            if (m_forced)      m_cg = 1'b1;
            else if (vid_req)  m_vg = 1'b1;
            else if (m_pend)   m_cg = 1'b1;
            m_accept = !m_pend && (c > m_ack_cycle) && cpu_req;

            if (reset) begin
                for (int k = c + 1; k <= c + 4; k++) begin
                    exp_vv[k] = 1'b0; exp_ack[k] = 1'b0; exp_rdc[k] = 1'b0;
                    exp_we[k] = 1'b0; exp_addr[k] = '0; exp_din[k] = 8'h00;
                end
                last_addr = '0; last_din = 8'h00;
                m_pend = 1'b0; m_waits = 0; m_ack_cycle = c;
            end else begin
                exp_we[c+1] = 1'b0; exp_addr[c+1] = last_addr; exp_din[c+1] = last_din;
                if (m_vg) begin
                    exp_addr[c+1] = vid_addr; last_addr = vid_addr;
                    exp_vv[c+3] = 1'b1; exp_vd[c+3] = shadow[vid_addr];
                    if (m_pend && m_waits < MAX_WAIT) m_waits++;
                end else if (m_cg) begin
                    exp_addr[c+1] = m_addr; last_addr = m_addr;
                    if (m_we) begin
                        exp_we[c+1] = 1'b1; exp_din[c+1] = m_wdata; last_din = m_wdata;
                        shadow[m_addr] = m_wdata;
                        exp_ack[c+1] = 1'b1; m_ack_cycle = c + 1;
                    end else begin
                        exp_ack[c+3] = 1'b1; exp_rdc[c+3] = 1'b1;
                        exp_rd[c+3] = shadow[m_addr]; m_ack_cycle = c + 3;
                    end
                    m_pend = 1'b0; m_waits = 0;
                end
                if (m_accept) begin
                    m_pend = 1'b1; m_waits = 0;
                    m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
                end
            end

            // ---- checks, away from the active edge ----
            @(negedge clock);
            if (c >= 1) begin
                check_eq("vid_grant", 32'(vid_grant), 32'(m_vg));
                check_eq("cpu_ack",   32'(cpu_ack),   32'(exp_ack[c]));
                if (exp_rdc[c]) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd[c]));
                check_eq("vid_valid", 32'(vid_valid), 32'(exp_vv[c]));
                if (exp_vv[c])  check_eq("vid_data", 32'(vid_data), 32'(exp_vd[c]));
                check_eq("vram_we",   32'(vram_we),   32'(exp_we[c]));
                check_eq("vram_addr", 32'(vram_addr), 32'(exp_addr[c]));
                check_eq("vram_din",  32'(vram_din),  32'(exp_din[c]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 16 KiB x 8 video_ram between the 6502 bus interface (CPU port) and the scan-out pixel fetcher (video port), one RAM access per clock.
- Video has priority. A starvation counter forces a CPU slot after MAX_WAIT lost cycles.
- Drives the RAM's we/address/data_in. Returns the RAM's data_out to whichever requester owns the in-flight read.

Parameters:
- MAX_WAIT, 7: maximum consecutive cycles a pending CPU access may lose to video before it is force-granted (range 1..15).
- ADDR_W, 14: VRAM address width.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU access request; level, held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  8  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  8  read data; valid while cpu_ack=1 for a read.
- vid_req  input  1  video read request, evaluated every cycle.
- vid_addr  input  ADDR_W  video read address.
- vid_grant  output  1  combinational; 1 = this cycle's vid_req is accepted.
- vid_valid  output  1  one-cycle pulse, vid_data valid.
- vid_data  output  8  video read data.
- vram_we  output  1  to video_ram we; registered.
- vram_addr  output  ADDR_W  to video_ram address; registered.
- vram_din  output  8  to video_ram data_in; registered.
- vram_dout  input  8  from video_ram data_out (synchronous read, valid after the edge that samples the address).

Behaviour:
- Reset values: cpu_ack=0, cpu_rdata=0, vid_valid=0, vid_data=0, vram_we=0, vram_addr=0, vram_din=0, wait counter=0, CPU FSM=C_IDLE, read pipeline cleared.
- CPU FSM:
  - C_IDLE: cpu_req=1 and cpu_ack=0 -> latch we/addr/wdata, go to C_PEND.
  - C_PEND: wait for a grant.
    - Granted write -> C_ACK.
    - Granted read -> C_RD1.
  - C_RD1 -> C_RD2 (RAM sampling).
  - C_RD2: capture vram_dout into cpu_rdata -> C_ACK.
  - C_ACK: cpu_ack=1 for exactly one cycle -> C_IDLE.
  - The latched request completes even if cpu_req drops early.
  - cpu_req seen while cpu_ack=1 is ignored; the requester must drop cpu_req after the ack.
- Grant decision, per cycle:
  - Forced CPU: CPU in C_PEND and wait counter == MAX_WAIT -> CPU granted, vid_grant=0.
  - Video: otherwise, vid_req=1 -> video granted, vid_grant=1.
  - Normal CPU: otherwise, CPU in C_PEND -> CPU granted.
  - Neither: vram_we=0 and vram_addr holds its last value.
- Wait counter:
  - Increments each cycle CPU is in C_PEND and loses to video.
  - Clears on CPU grant and in C_IDLE.
  - Saturates at MAX_WAIT.
- Grant registers: at the granting edge, vram_addr, vram_we (1 only for a CPU write) and vram_din (cpu wdata for a write) are loaded.
  - vram_we is 1 for exactly one cycle per write.
- Read latency:
  - Video read granted in cycle n -> vid_valid=1 with vid_data in cycle n+3.
  - The RAM samples at edge n+2; vid_data is registered at edge n+3.
  - Video reads fully pipeline: back-to-back grants give back-to-back vid_valid.
  - CPU read: granted in cycle n -> cpu_ack with cpu_rdata in cycle n+3.
  - CPU write: granted in cycle n -> cpu_ack in cycle n+1.
- A one-bit-per-stage owner tag travels with each read so returned data is never misrouted when CPU and video reads interleave.
- Address arithmetic: none; addresses pass through unmodified, width ADDR_W, no wrap logic.
- Reset mid-operation: in-flight reads are discarded (no vid_valid, no cpu_ack), a pending CPU request is dropped, and vram_we=0 the next cycle.

Test Plan:
- CPU write, video idle: cpu_req=1, we=1, addr=0x0001, wdata=0xAB -> vram_we=1, vram_addr=0x0001, vram_din=0xAB for one cycle; cpu_ack one cycle later.
- CPU read-back: read addr=0x0001 -> cpu_ack with cpu_rdata=0xAB exactly 3 cycles after grant; read 0x0002 (unwritten) -> ack with that location's contents, no misroute.
- Video streaming: vid_req=1 for addresses 0x0100..0x010F on consecutive cycles -> 16 consecutive vid_valid pulses, data in order, first 3 cycles after first grant.
- Starvation: video requests continuously with a pending CPU write; MAX_WAIT=7 -> CPU granted on the 8th cycle (vid_grant=0 that cycle), then video resumes; the video read issued just before is returned correctly.
- Interleaved reads: CPU read 0x0003 (preloaded 0x5A) force-granted between video reads of 0x0004/0x0005 -> cpu_rdata=0x5A; vid_data matches RAM; no crossed data.
- Reset mid-read: assert reset one cycle after a CPU read grant -> no cpu_ack; all outputs 0 the next cycle; a new request after reset completes normally.
